// File: rtl/dcache_assoc_if.sv
// ============================================================================
// Module   : dcache_assoc_if
// Purpose  : Consumer (LSU) and block-wide memory channel bundle for dcache_assoc.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dcache_assoc_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int BLOCK_WORDS   = 4
) ();
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [BLOCK_WORDS*DATA_BITS-1:0]   mem_read_data;
  logic                               mem_write_valid;
  logic [ADDR_BITS-1:0]               mem_write_address;
  logic [BLOCK_WORDS*DATA_BITS-1:0]   mem_write_data;
  logic                               mem_write_ready;

  // Cache view: serves consumers, masters the memory channel.
  modport slave (
    input  consumer_read_valid, consumer_read_address,
    output consumer_read_ready, consumer_read_data,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport master (
    output consumer_read_valid, consumer_read_address,
    input  consumer_read_ready, consumer_read_data,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

`default_nettype wire

// File: rtl/dcache_assoc.sv
// ============================================================================
// Module   : dcache_assoc
// Purpose  : Blocking write-back/write-allocate N-way cache, true-LRU, RR consumers.
//            Optional event counters: define DCACHE_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_assoc #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_SETS      = 4,
  parameter int NUM_WAYS      = 2,
  parameter int BLOCK_WORDS   = 4
) (
  input  logic          clk,
  input  logic          reset,
  dcache_assoc_if.slave bus,
  output logic [15:0]   stat_hits,
  output logic [15:0]   stat_misses,
  output logic [15:0]   stat_writebacks
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = ADDR_BITS - SET_W - OFF_W;
  localparam int CID_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int BLK_W = BLOCK_WORDS * DATA_BITS;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL      = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [CID_W-1:0]        rr_q, cid_q;
  logic                    op_wr_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [DATA_BITS-1:0]    wdata_q;
  logic [WAY_W-1:0]        way_q;

  logic                    valid_q [NUM_SETS][NUM_WAYS];
  logic                    dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]        tag_q   [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0]        data_q  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]        age_q   [NUM_SETS][NUM_WAYS];

  logic [NUM_CONSUMERS-1:0]                rd_ready_q, wr_ready_q;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q;
  logic                                    mrv_q, mwv_q;
  logic [ADDR_BITS-1:0]                    mra_q, mwa_q;
  logic [BLK_W-1:0]                        mwd_q;

  assign bus.consumer_read_ready  = rd_ready_q;
  assign bus.consumer_read_data   = rd_data_q;
  assign bus.consumer_write_ready = wr_ready_q;
  assign bus.mem_read_valid       = mrv_q;
  assign bus.mem_read_address     = mra_q;
  assign bus.mem_write_valid      = mwv_q;
  assign bus.mem_write_address    = mwa_q;
  assign bus.mem_write_data       = mwd_q;

  // Round-robin arbitration: rotate eligibility so the pointer lands on bit 0.
  logic [NUM_CONSUMERS-1:0]   elig_w, rot_w;
  logic [2*NUM_CONSUMERS-1:0] dbl_w;
  logic [CID_W-1:0]           offset_w, grant_w, next_rr_w;
  logic [CID_W:0]             grant_sum_w;

  assign elig_w = (bus.consumer_read_valid | bus.consumer_write_valid) & ~rd_ready_q & ~wr_ready_q;
  assign dbl_w  = {elig_w, elig_w} >> rr_q;
  assign rot_w  = dbl_w[NUM_CONSUMERS-1:0];

  always_comb begin
    offset_w = '0;
    for (int j = NUM_CONSUMERS - 1; j >= 0; j--) begin
      if (rot_w[j]) offset_w = CID_W'(j);
    end
  end

  assign grant_sum_w = {1'b0, rr_q} + {1'b0, offset_w};
  assign grant_w     = (grant_sum_w >= (CID_W+1)'(NUM_CONSUMERS))
                     ? CID_W'(grant_sum_w - (CID_W+1)'(NUM_CONSUMERS))
                     : grant_sum_w[CID_W-1:0];
  assign next_rr_w   = (grant_w == CID_W'(NUM_CONSUMERS - 1)) ? '0 : grant_w + CID_W'(1);

  logic [SET_W-1:0] set_w;
  logic [TAG_W-1:0] tag_w;
  logic [OFF_W-1:0] off_w;
  assign set_w = addr_q[OFF_W +: SET_W];
  assign tag_w = addr_q[ADDR_BITS-1 -: TAG_W];
  assign off_w = addr_q[OFF_W-1:0];

  logic             hit_w, inv_found_w;
  logic [WAY_W-1:0] hit_way_w, victim_w;

  always_comb begin
    hit_w       = 1'b0;
    hit_way_w   = '0;
    inv_found_w = 1'b0;
    victim_w    = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_w][w] && (tag_q[set_w][w] == tag_w)) begin
        hit_w     = 1'b1;
        hit_way_w = WAY_W'(w);
      end
      if (!valid_q[set_w][w]) begin
        inv_found_w = 1'b1;
        victim_w    = WAY_W'(w);
      end
    end
    if (!inv_found_w) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[set_w][w] == WAY_W'(NUM_WAYS - 1)) victim_w = WAY_W'(w);
      end
    end
  end

  // Completion is committed on the edge that enters RESPOND, so ready is visible during RESPOND.
  logic                 do_respond_w, new_dirty_w;
  logic [WAY_W-1:0]     acc_way_w;
  logic [BLK_W-1:0]     base_blk_w, merged_blk_w;
  logic [DATA_BITS-1:0] rd_word_w;
  logic [WAY_W-1:0]     new_age_w [NUM_WAYS];

  assign do_respond_w = ((state_q == S_LOOKUP) && hit_w) ||
                        ((state_q == S_FILL) && bus.mem_read_ready);
  assign acc_way_w    = (state_q == S_FILL) ? way_q : hit_way_w;
  assign base_blk_w   = (state_q == S_FILL) ? bus.mem_read_data : data_q[set_w][hit_way_w];
  assign new_dirty_w  = op_wr_q | ((state_q == S_LOOKUP) & dirty_q[set_w][hit_way_w]);

  always_comb begin
    merged_blk_w = base_blk_w;
    rd_word_w    = '0;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (off_w == OFF_W'(k)) begin
        rd_word_w = base_blk_w[k*DATA_BITS +: DATA_BITS];
        if (op_wr_q) merged_blk_w[k*DATA_BITS +: DATA_BITS] = wdata_q;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      new_age_w[w] = age_q[set_w][w];
      if (WAY_W'(w) == acc_way_w)                         new_age_w[w] = '0;
      else if (age_q[set_w][w] < age_q[set_w][acc_way_w]) new_age_w[w] = age_q[set_w][w] + WAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      cid_q      <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      way_q      <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
      mrv_q      <= 1'b0;
      mwv_q      <= 1'b0;
      mra_q      <= '0;
      mwa_q      <= '0;
      mwd_q      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|elig_w) begin
            cid_q   <= grant_w;
            op_wr_q <= bus.consumer_write_valid[grant_w];
            addr_q  <= bus.consumer_write_valid[grant_w] ? bus.consumer_write_address[grant_w]
                                                        : bus.consumer_read_address[grant_w];
            wdata_q <= bus.consumer_write_data[grant_w];
            rr_q    <= next_rr_w;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_w) begin
            state_q <= S_RESPOND;
          end else begin
            way_q <= victim_w;
            if (valid_q[set_w][victim_w] && dirty_q[set_w][victim_w]) begin
              mwv_q   <= 1'b1;
              mwa_q   <= {tag_q[set_w][victim_w], set_w, {OFF_W{1'b0}}};
              mwd_q   <= data_q[set_w][victim_w];
              state_q <= S_WRITEBACK;
            end else begin
              mrv_q   <= 1'b1;
              mra_q   <= {tag_w, set_w, {OFF_W{1'b0}}};
              state_q <= S_FILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_write_ready) begin
            mwv_q                 <= 1'b0;
            dirty_q[set_w][way_q] <= 1'b0;
            mrv_q                 <= 1'b1;
            mra_q                 <= {tag_w, set_w, {OFF_W{1'b0}}};
            state_q               <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.mem_read_ready) begin
            mrv_q   <= 1'b0;
            state_q <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          rd_ready_q <= '0;
          wr_ready_q <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (do_respond_w) begin
        data_q[set_w][acc_way_w]  <= merged_blk_w;
        tag_q[set_w][acc_way_w]   <= tag_w;
        valid_q[set_w][acc_way_w] <= 1'b1;
        dirty_q[set_w][acc_way_w] <= new_dirty_w;
        for (int w = 0; w < NUM_WAYS; w++) age_q[set_w][w] <= new_age_w[w];
        if (op_wr_q) begin
          wr_ready_q[cid_q] <= 1'b1;
        end else begin
          rd_ready_q[cid_q] <= 1'b1;
          rd_data_q[cid_q]  <= rd_word_w;
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hits_q, misses_q, wbs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if (state_q == S_LOOKUP) begin
        if (hit_w) begin
          if (hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
        end else begin
          if (misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
        end
      end
      if ((state_q == S_WRITEBACK) && bus.mem_write_ready && (wbs_q != 16'hFFFF)) begin
        wbs_q <= wbs_q + 16'd1;
      end
    end
  end

  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;
`else
  assign stat_hits       = 16'd0;
  assign stat_misses     = 16'd0;
  assign stat_writebacks = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_assoc.sv
// ============================================================================
// Module   : tb_dcache_assoc
// Purpose  : Directed + random bench for dcache_assoc against a flat-memory /
//            recency-list reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_assoc;
  localparam int AB = 8, DB = 8, NC = 8, NS = 4, NW = 2, BW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] stat_hits, stat_misses, stat_writebacks;

  always #5 clk = ~clk;

  dcache_assoc_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .BLOCK_WORDS(BW)) bus ();

  dcache_assoc #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
    .NUM_SETS(NS), .NUM_WAYS(NW), .BLOCK_WORDS(BW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses),
    .stat_writebacks(stat_writebacks)
  );

  int checks = 0;
  int errors = 0;

  // Reference: gmem is what a coherent memory would hold; bmem is the backing store behind the cache.
  logic [7:0] bmem [256];
  logic [7:0] gmem [256];
  bit         mv [NS][NW];
  bit         md [NS][NW];
  logic [3:0] mt [NS][NW];
  int         rec [NS][$];
  int         exp_hits, exp_misses, exp_wbs;
  int         last_wb_addr;
  logic [31:0] last_wb_data;
  logic [7:0] last_rd;
  bit         last_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      rec[s].delete();
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 0;
        md[s][w] = 0;
        rec[s].push_back(w);
      end
    end
    for (int a = 0; a < 256; a++) gmem[a] = bmem[a];
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
  endfunction

  function automatic void touch(input int s, input int w);
    for (int i = 0; i < rec[s].size(); i++) begin
      if (rec[s][i] == w) begin
        rec[s].delete(i);
        break;
      end
    end
    rec[s].push_front(w);
  endfunction

  function automatic int find_way(input logic [7:0] addr);
    int hw = -1;
    for (int w = 0; w < NW; w++) begin
      if (mv[addr[3:2]][w] && mt[addr[3:2]][w] == addr[7:4]) hw = w;
    end
    return hw;
  endfunction

  task automatic check_stats();
    check("stat_hits", {16'd0, stat_hits}, exp_hits);
    check("stat_misses", {16'd0, stat_misses}, exp_misses);
    check("stat_writebacks", {16'd0, stat_writebacks}, exp_wbs);
  endtask

  task automatic access(input int cid, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    logic [1:0]  st = addr[3:2];
    logic [3:0]  tg = addr[7:4];
    int          hw = find_way(addr);
    int          vw = -1;
    int          n = 0, fill_n = -1, wdly = 0, rdly = 0;
    bit          exp_wb = 0, wb_seen = 0, fill_seen = 0, done = 0;
    logic [7:0]  wba = '0, fa, rd = 'x;
    logic [31:0] eb, fb;

    fa = {tg, st, 2'b00};
    if (hw < 0) begin
      for (int w = NW - 1; w >= 0; w--) if (!mv[st][w]) vw = w;
      if (vw < 0) vw = rec[st][$];
      exp_wb = mv[st][vw] && md[st][vw];
      wba    = {mt[st][vw], st, 2'b00};
    end

    if (wr) begin
      bus.consumer_write_valid[cid]   = 1'b1;
      bus.consumer_write_address[cid] = addr;
      bus.consumer_write_data[cid]    = wd;
    end else begin
      bus.consumer_read_valid[cid]   = 1'b1;
      bus.consumer_read_address[cid] = addr;
    end

    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      check("mem_excl", {31'd0, bus.mem_read_valid & bus.mem_write_valid}, 0);
      if (bus.mem_write_ready) begin
        bus.mem_write_ready = 1'b0;
        check("wb_drop", {31'd0, bus.mem_write_valid}, 0);
      end else if (bus.mem_write_valid) begin
        if (!wb_seen) begin
          wb_seen = 1;
          for (int k = 0; k < BW; k++) eb[k*8 +: 8] = gmem[int'(wba) + k];
          check("wb_addr", {24'd0, bus.mem_write_address}, {24'd0, wba});
          check("wb_data", bus.mem_write_data, eb);
          wdly = $urandom_range(0, 2);
        end
        if (wdly == 0) begin
          bus.mem_write_ready = 1'b1;
          for (int k = 0; k < BW; k++)
            bmem[int'(bus.mem_write_address) + k] = bus.mem_write_data[k*8 +: 8];
          last_wb_addr = int'(bus.mem_write_address);
          last_wb_data = bus.mem_write_data;
        end else wdly--;
      end
      if (bus.mem_read_ready) begin
        bus.mem_read_ready = 1'b0;
        check("fill_drop", {31'd0, bus.mem_read_valid}, 0);
      end else if (bus.mem_read_valid) begin
        if (!fill_seen) begin
          fill_seen = 1;
          check("fill_addr", {24'd0, bus.mem_read_address}, {24'd0, fa});
          rdly = $urandom_range(0, 3);
        end
        if (rdly == 0) begin
          for (int k = 0; k < BW; k++) fb[k*8 +: 8] = bmem[int'(fa) + k];
          bus.mem_read_data  = fb;
          bus.mem_read_ready = 1'b1;
          fill_n = n;
        end else rdly--;
      end
      if (wr ? bus.consumer_write_ready[cid] : bus.consumer_read_ready[cid]) begin
        done = 1;
        rd   = bus.consumer_read_data[cid];
      end
    end

    bus.consumer_read_valid[cid]  = 1'b0;
    bus.consumer_write_valid[cid] = 1'b0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;

    check("done", {31'd0, done}, 1);
    if (hw >= 0) begin
      check("hit_latency", n, 2);
      check("hit_traffic", {31'd0, wb_seen | fill_seen}, 0);
    end else begin
      check("fill_seen", {31'd0, fill_seen}, 1);
      check("wb_seen", {31'd0, wb_seen}, {31'd0, exp_wb});
      check("miss_latency", n - fill_n, 1);
    end
    if (!wr) check("rdata", {24'd0, rd}, {24'd0, gmem[addr]});

    if (hw < 0) begin
      mv[st][vw] = 1;
      mt[st][vw] = tg;
      md[st][vw] = 0;
`ifdef DCACHE_STATS_EN
      exp_misses++;
      if (exp_wb) exp_wbs++;
`endif
      hw = vw;
      last_hit = 0;
    end else begin
`ifdef DCACHE_STATS_EN
      exp_hits++;
`endif
      last_hit = 1;
    end
    if (wr) begin
      md[st][hw] = 1;
      gmem[addr] = wd;
    end
    touch(int'(st), hw);
    last_rd = rd;
    @(negedge clk);
    check_stats();
  endtask

  // Consumers 0 and 3 issue read hits in the same cycle; 0 must win and 3 follows.
  task automatic pair_hits(input logic [7:0] a0, input logic [7:0] a3);
    int hw0 = find_way(a0);
    int hw3 = find_way(a3);
    int n = 0, t0 = -1, t3 = -1;
    bit any_mem = 0;
    logic [7:0] d0 = 'x, d3 = 'x;

    check("pair_pre_hit0", {31'd0, hw0 >= 0}, 1);
    check("pair_pre_hit3", {31'd0, hw3 >= 0}, 1);
    bus.consumer_read_valid[0] = 1'b1; bus.consumer_read_address[0] = a0;
    bus.consumer_read_valid[3] = 1'b1; bus.consumer_read_address[3] = a3;
    while ((t0 < 0 || t3 < 0) && n < 50) begin
      @(negedge clk);
      n++;
      any_mem |= bus.mem_read_valid | bus.mem_write_valid;
      if (bus.consumer_read_ready[0] && t0 < 0) begin
        t0 = n; d0 = bus.consumer_read_data[0]; bus.consumer_read_valid[0] = 1'b0;
      end
      if (bus.consumer_read_ready[3] && t3 < 0) begin
        t3 = n; d3 = bus.consumer_read_data[3]; bus.consumer_read_valid[3] = 1'b0;
      end
    end
    bus.consumer_read_valid[0] = 1'b0;
    bus.consumer_read_valid[3] = 1'b0;
    check("pair_c0_cycle", t0, 2);
    check("pair_c3_cycle", t3, 5);
    check("pair_c0_data", {24'd0, d0}, {24'd0, gmem[a0]});
    check("pair_c3_data", {24'd0, d3}, {24'd0, gmem[a3]});
    check("pair_no_mem", {31'd0, any_mem}, 0);
    if (hw0 >= 0) touch(int'(a0[3:2]), hw0);
    if (hw3 >= 0) touch(int'(a3[3:2]), hw3);
`ifdef DCACHE_STATS_EN
    exp_hits += 2;
`endif
    @(negedge clk);
    check_stats();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    reset = 1'b1;
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_read_data   = '0;
    bus.mem_write_ready = 1'b0;
    for (int a = 0; a < 256; a++) bmem[a] = 8'($urandom);
    bmem[8'h10] = 8'h11; bmem[8'h11] = 8'h22; bmem[8'h12] = 8'h33; bmem[8'h13] = 8'h44;
    model_reset();
    last_wb_addr = -1;

    repeat (3) @(negedge clk);
    check("rst_mem_read_valid", {31'd0, bus.mem_read_valid}, 0);
    check("rst_mem_write_valid", {31'd0, bus.mem_write_valid}, 0);
    check("rst_read_ready", {24'd0, bus.consumer_read_ready}, 0);
    check("rst_write_ready", {24'd0, bus.consumer_write_ready}, 0);
    check("rst_read_data", bus.consumer_read_data[3:0], 0);
    check("rst_mem_read_addr", {24'd0, bus.mem_read_address}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_stats();

    // Cold read miss then hit in the same block.
    access(0, 0, 8'h13, 8'h00);
    check("t1_cold_data", {24'd0, last_rd}, 32'h44);
    access(1, 0, 8'h12, 8'h00);
    check("t1_hit_data", {24'd0, last_rd}, 32'h33);
`ifdef DCACHE_STATS_EN
    check("t6_hits", {16'd0, stat_hits}, 1);
    check("t6_misses", {16'd0, stat_misses}, 1);
`else
    check("t6_hits", {16'd0, stat_hits}, 0);
    check("t6_misses", {16'd0, stat_misses}, 0);
`endif
    check("t6_writebacks", {16'd0, stat_writebacks}, 0);

    // Dirty victim eviction.
    access(2, 1, 8'h13, 8'hAA);
    access(2, 0, 8'h53, 8'h00);
    access(2, 0, 8'h93, 8'h00);
    check("t2_wb_addr", last_wb_addr, 32'h10);
    check("t2_wb_word3", {24'd0, last_wb_data[31:24]}, 32'hAA);

    // Write-allocate on a cold set.
    last_wb_addr = -1;
    access(7, 1, 8'h27, 8'h5C);
    check("t3_no_wb", last_wb_addr, -1);
    access(7, 0, 8'h27, 8'h00);
    check("t3_readback", {24'd0, last_rd}, 32'h5C);

    pair_hits(8'h52, 8'h91);
    pair_hits(8'h52, 8'h91);

    // Reset while a fill is outstanding.
    bus.consumer_read_valid[1]   = 1'b1;
    bus.consumer_read_address[1] = 8'hE1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.mem_read_valid) seen = 1;
    end
    check("t5_fill_started", seen, 1);
    reset = 1'b1;
    bus.consumer_read_valid[1] = 1'b0;
    @(negedge clk);
    check("t5_mem_read_valid", {31'd0, bus.mem_read_valid}, 0);
    check("t5_mem_write_valid", {31'd0, bus.mem_write_valid}, 0);
    check("t5_read_ready", {24'd0, bus.consumer_read_ready}, 0);
    check("t5_write_ready", {24'd0, bus.consumer_write_ready}, 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    access(1, 0, 8'hE1, 8'h00);
    check("t5_reread_miss", {31'd0, last_hit}, 0);

    for (int i = 0; i < 150; i++) begin
      access(int'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 95)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
